regbank_mp: RTL and testbench

- Parametrised successor to the core register bank: configurable data width, register count and read-port count.
- Two write ports: port 0 for ALU writeback, port 1 for late load writeback.
- Write-first bypass on every read port; x0 hardwired to zero.
- Per-register pending-write scoreboard for hazard detection, plus a sequential bulk-clear engine used on context reset.
- Sits between decode (reads, marks) and writeback (writes) in the pipeline.

---
 rtl/regbank_pkg.sv | 19 +
 rtl/regbank_scoreboard.sv | 50 +++++
 rtl/regbank_mp.sv | 146 ++++++++++++++
 tb/tb_regbank_mp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the multi-port register bank: clear FSM states,
// default geometry and packed-port slicing helper.
package regbank_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // LSB position of port `port` inside a packed bus of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set by issue
// marks, cleared by writeback or by the bulk-clear engine.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr_en,
  input  logic [AW-1:0]    i_clr_idx,
  input  logic             i_we0,
  input  logic [AW-1:0]    i_wa0,
  input  logic             i_we1,
  input  logic [AW-1:0]    i_wa1,
  input  logic             i_mark,
  input  logic [AW-1:0]    i_mark_addr,
  output logic [NREGS-1:0] o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) begin
      w_pending_nxt[i_clr_idx] = 1'b0;
    end else begin
      if (i_we0) w_pending_nxt[i_wa0] = 1'b0;
      if (i_we1) w_pending_nxt[i_wa1] = 1'b0;
      // Applied after the clears: a new producer supersedes a retiring one.
      if (i_mark) w_pending_nxt[i_mark_addr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regbank_mp.sv
// Parametrised register bank: two write ports, NUM_RD bypassed read ports,
// pending-write scoreboard and a sequential bulk-clear engine.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr_i,
  output logic [NUM_RD*XLEN-1:0] rs_data_o,
  output logic [NUM_RD-1:0]      rs_pending_o,
  input  logic                   we0_i,
  input  logic [AW-1:0]          wa0_i,
  input  logic [XLEN-1:0]        wd0_i,
  input  logic                   we1_i,
  input  logic [AW-1:0]          wa1_i,
  input  logic [XLEN-1:0]        wd1_i,
  input  logic                   mark_i,
  input  logic [AW-1:0]          mark_addr_i,
  input  logic                   clear_req_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  clr_state_e       r_state;
  clr_state_e       w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_pending;
  logic             w_clearing;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_mark;

  assign w_clearing = (r_state == CLEAR);
  assign w_wr0      = we0_i && !w_clearing && (wa0_i != '0);
  assign w_wr1      = we1_i && !w_clearing && (wa1_i != '0);
  assign w_mark     = mark_i && !w_clearing && (mark_addr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (clear_req_i) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        busy_o = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = DONE;
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (r_state == IDLE && clear_req_i) begin
      r_idx <= AW'(1);
    end else if (w_clearing && r_idx != LAST_IDX) begin
      r_idx <= r_idx + AW'(1);
    end
  end

  // NOTE: the array is built from flops, not a RAM macro, so it can take the
  // asynchronous reset; context reset relies on every register reading zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_clearing) begin
      r_regs[r_idx] <= '0;
    end else begin
      // NOTE: non-blocking assignments to the same element resolve to the
      // last one executed, so port 0 is written second to win a collision.
      if (w_wr1) r_regs[wa1_i] <= wd1_i;
      if (w_wr0) r_regs[wa0_i] <= wd0_i;
    end
  end

  regbank_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_clr_en    (w_clearing),
    .i_clr_idx   (r_idx),
    .i_we0       (w_wr0),
    .i_wa0       (wa0_i),
    .i_we1       (w_wr1),
    .i_wa1       (wa1_i),
    .i_mark      (w_mark),
    .i_mark_addr (mark_addr_i),
    .o_pending   (w_pending)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic            w_hit0;
    logic            w_hit1;
    logic [XLEN-1:0] w_data;
    logic            w_pend;

    assign w_addr = rs_addr_i[port_lsb(k, AW) +: AW];
    assign w_hit0 = we0_i && (wa0_i == w_addr);
    assign w_hit1 = we1_i && (wa1_i == w_addr);

    // While clearing, reads see raw array contents with no bypass or hazard.
    always_comb begin
      w_data = r_regs[w_addr];
      w_pend = 1'b0;
      if (w_addr == '0) begin
        w_data = '0;
      end else if (!w_clearing) begin
        if (w_hit0) begin
          w_data = wd0_i;
        end else if (w_hit1) begin
          w_data = wd1_i;
        end
        w_pend = w_pending[w_addr] && !(w_hit0 || w_hit1);
      end
    end

    assign rs_data_o[port_lsb(k, XLEN) +: XLEN] = w_data;
    assign rs_pending_o[k]                      = w_pend;
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: vector table for bypass/scoreboard behaviour,
// hand sequences for bulk clear and reset during clear.
module tb_regbank_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rs_addr_i;
  logic [NUM_RD*XLEN-1:0] rs_data_o;
  logic [NUM_RD-1:0]      rs_pending_o;
  logic                   we0_i;
  logic [AW-1:0]          wa0_i;
  logic [XLEN-1:0]        wd0_i;
  logic                   we1_i;
  logic [AW-1:0]          wa1_i;
  logic [XLEN-1:0]        wd1_i;
  logic                   mark_i;
  logic [AW-1:0]          mark_addr_i;
  logic                   clear_req_i;
  logic                   busy_o;
  logic                   done_o;

  int checks   = 0;
  int failures = 0;

  regbank_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_addr_i    (rs_addr_i),
    .rs_data_o    (rs_data_o),
    .rs_pending_o (rs_pending_o),
    .we0_i        (we0_i),
    .wa0_i        (wa0_i),
    .wd0_i        (wd0_i),
    .we1_i        (we1_i),
    .wa1_i        (wa1_i),
    .wd1_i        (wd1_i),
    .mark_i       (mark_i),
    .mark_addr_i  (mark_addr_i),
    .clear_req_i  (clear_req_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        mark;
    logic [4:0]  ma;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        ep0;
    logic        ep1;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic mrk, input logic [4:0] ma,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic ep0, input logic ep1);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.mark = mrk; v.ma = ma;
    v.ed0 = ed0; v.ed1 = ed1; v.ep0 = ep0; v.ep1 = ep1;
    return v;
  endfunction

  function automatic logic [31:0] fillval(input int i);
    return 32'(i) * 32'h0101_0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs_addr_i   = '0;
    we0_i       = 1'b0;
    wa0_i       = '0;
    wd0_i       = '0;
    we1_i       = 1'b0;
    wa1_i       = '0;
    wd1_i       = '0;
    mark_i      = 1'b0;
    mark_addr_i = '0;
    clear_req_i = 1'b0;
  endtask

  // Writes fillval(i) to every x1..x31 and marks each one in the same cycle.
  task automatic fill_all();
    for (int i = 1; i < NREGS; i++) begin
      we0_i       = 1'b1;
      wa0_i       = 5'(i);
      wd0_i       = fillval(i);
      mark_i      = 1'b1;
      mark_addr_i = 5'(i);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  vec_t vecs [19];
  int   busy_cnt;
  int   done_early;
  int   guard;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            ra0 ra1 we0 wa0 wd0           we1 wa1 wd1          mk ma  ed0           ed1           p0 p1
    vecs[0]  = mk(5,  0,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(5,  5,  1,  5,  32'hDEADBEEF, 0,  0,  32'h0,       0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(5,  7,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'hDEADBEEF, 32'h0,        0, 0);
    vecs[3]  = mk(7,  7,  1,  7,  32'h11,       1,  7,  32'h22,      0, 0,  32'h11,       32'h11,       0, 0);
    vecs[4]  = mk(7,  5,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h11,       32'hDEADBEEF, 0, 0);
    vecs[5]  = mk(9,  9,  0,  0,  32'h0,        0,  0,  32'h0,       1, 9,  32'h0,        32'h0,        0, 0);
    vecs[6]  = mk(9,  9,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h0,        32'h0,        1, 1);
    vecs[7]  = mk(9,  5,  0,  0,  32'h0,        1,  9,  32'h55,      0, 0,  32'h55,       32'hDEADBEEF, 0, 0);
    vecs[8]  = mk(9,  9,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h55,       32'h55,       0, 0);
    vecs[9]  = mk(9,  9,  1,  9,  32'h66,       0,  0,  32'h0,       1, 9,  32'h66,       32'h66,       0, 0);
    vecs[10] = mk(9,  9,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h66,       32'h66,       1, 1);
    vecs[11] = mk(9,  10, 0,  0,  32'h0,        1,  10, 32'hAB,      0, 0,  32'h66,       32'hAB,       1, 0);
    vecs[12] = mk(0,  0,  1,  0,  32'hFFFFFFFF, 0,  0,  32'h0,       1, 0,  32'h0,        32'h0,        0, 0);
    vecs[13] = mk(0,  10, 0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h0,        32'hAB,       0, 0);
    vecs[14] = mk(10, 0,  0,  0,  32'h0,        0,  0,  32'h0,       1, 10, 32'hAB,       32'h0,        0, 0);
    vecs[15] = mk(10, 10, 1,  10, 32'h77,       0,  0,  32'h0,       0, 0,  32'h77,       32'h77,       0, 0);
    vecs[16] = mk(10, 9,  0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'h77,       32'h66,       0, 1);
    vecs[17] = mk(13, 12, 1,  12, 32'hC0FFEE,   1,  13, 32'hBADF00D, 0, 0,  32'hBADF00D,  32'hC0FFEE,   0, 0);
    vecs[18] = mk(12, 13, 0,  0,  32'h0,        0,  0,  32'h0,       0, 0,  32'hC0FFEE,   32'hBADF00D,  0, 0);

    rst = 1'b1;
    idle_inputs();
    rs_addr_i = {5'd5, 5'd7};
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_data", rs_data_o[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < $size(vecs); i++) begin
      rs_addr_i   = {vecs[i].ra1, vecs[i].ra0};
      we0_i       = vecs[i].we0;
      wa0_i       = vecs[i].wa0;
      wd0_i       = vecs[i].wd0;
      we1_i       = vecs[i].we1;
      wa1_i       = vecs[i].wa1;
      wd1_i       = vecs[i].wd1;
      mark_i      = vecs[i].mark;
      mark_addr_i = vecs[i].ma;
      #1;
      check($sformatf("v%0d_d0", i), rs_data_o[31:0], vecs[i].ed0);
      check($sformatf("v%0d_d1", i), rs_data_o[63:32], vecs[i].ed1);
      check($sformatf("v%0d_p0", i), 32'(rs_pending_o[0]), 32'(vecs[i].ep0));
      check($sformatf("v%0d_p1", i), 32'(rs_pending_o[1]), 32'(vecs[i].ep1));
      @(negedge clk);
    end
    idle_inputs();

    // Bulk clear with dropped writes/marks during CLEAR.
    fill_all();
    rs_addr_i = {5'd20, 5'd20};
    #1;
    check("pre_clr_pend", 32'(rs_pending_o[0]), 32'd1);
    check("pre_clr_busy", 32'(busy_o), 32'd0);
    clear_req_i = 1'b1;
    @(negedge clk);
    clear_req_i = 1'b0;
    busy_cnt   = 0;
    done_early = 0;
    guard      = 0;
    while (busy_o && guard < 100) begin
      busy_cnt++;
      guard++;
      if (done_o) done_early++;
      if (busy_cnt == 1) begin
        rs_addr_i = {5'd20, 5'd31};
        we0_i = 1'b1; wa0_i = 5'd31; wd0_i = 32'hCAFE;
        we1_i = 1'b1; wa1_i = 5'd20; wd1_i = 32'hBEEF;
        #1;
        check("clr_raw_d0", rs_data_o[31:0], fillval(31));
        check("clr_raw_d1", rs_data_o[63:32], fillval(20));
        check("clr_pend", 32'(rs_pending_o), 32'd0);
      end
      if (busy_cnt == 20) begin
        we0_i = 1'b1; wa0_i = 5'd3; wd0_i = 32'hCAFE;
        mark_i = 1'b1; mark_addr_i = 5'd3;
      end
      @(negedge clk);
      idle_inputs();
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
    check("clr_done_early", 32'(done_early), 32'd0);
    check("clr_done_pulse", 32'(done_o), 32'd1);
    check("clr_done_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("clr_done_low", 32'(done_o), 32'd0);
    for (int i = 0; i < NREGS; i++) begin
      rs_addr_i = {5'(i), 5'(i)};
      #1;
      check($sformatf("clr_x%0d_data", i), rs_data_o[31:0], 32'h0);
      check($sformatf("clr_x%0d_pend", i), 32'(rs_pending_o[0]), 32'd0);
    end
    idle_inputs();
    @(negedge clk);

    // Reset asserted mid-clear at idx 12.
    fill_all();
    clear_req_i = 1'b1;
    @(negedge clk);
    clear_req_i = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    rs_addr_i = {5'd13, 5'd30};
    #1;
    check("mid_busy_drop", 32'(busy_o), 32'd0);
    check("mid_done", 32'(done_o), 32'd0);
    check("mid_x30", rs_data_o[31:0], 32'h0);
    check("mid_x13", rs_data_o[63:32], 32'h0);
    check("mid_pend", 32'(rs_pending_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    we0_i = 1'b1; wa0_i = 5'd3; wd0_i = 32'h1234;
    rs_addr_i = {5'd13, 5'd3};
    #1;
    check("post_rst_bypass", rs_data_o[31:0], 32'h1234);
    @(negedge clk);
    we0_i = 1'b0;
    #1;
    check("post_rst_x3", rs_data_o[31:0], 32'h1234);
    check("post_rst_x13", rs_data_o[63:32], 32'h0);
    check("post_rst_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
